// File: rtl/traffic_monitor.sv
// Lamp-bus observer: synchronizes and debounces the active-low lamp outputs,
// decodes them into a controller phase and flags order, pattern and dwell faults.
module traffic_monitor #(
  parameter int STABLE    = 4,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 12,
  parameter int YEL_MIN   = 3,
  parameter int YEL_MAX   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [5:0]  lamps,
  input  logic        clr_err,
  output logic [1:0]  phase,
  output logic        locked,
  output logic [7:0]  dwell,
  output logic [15:0] cycles,
  output logic        err_pattern,
  output logic        err_order,
  output logic        err_time,
  output logic        err_any
);
  localparam logic [3:0] CNT_TOP = 4'(STABLE - 1);
  localparam logic [7:0] G_MIN = 8'(GREEN_MIN);
  localparam logic [7:0] G_MAX = 8'(GREEN_MAX);
  localparam logic [7:0] Y_MIN = 8'(YEL_MIN);
  localparam logic [7:0] Y_MAX = 8'(YEL_MAX);

  typedef enum logic {UNLOCKED, TRACK} state_t;
  state_t state, state_n;

  logic [5:0]  s1, s2, cand, acc;
  logic [3:0]  cnt;
  logic        accept, legal, partial, partial_n;
  logic [1:0]  dec, succ, phase_n;
  logic [7:0]  dwell_n, dwell_inc, min_cur, max_cur;
  logic [15:0] cycles_n;
  logic        set_pat, set_ord, set_time;
  logic        ep_n, eo_n, et_n;

  // Debounce: a pattern is taken once it has held long enough and differs from the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 6'b111111;
      s2   <= 6'b111111;
      cand <= 6'b111111;
      acc  <= 6'b111111;
      cnt  <= '0;
    end else begin
      s1 <= lamps;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt != CNT_TOP) begin
        cnt <= cnt + 4'd1;
      end
      if (accept) acc <= cand;
    end
  end

  assign accept = (cnt == CNT_TOP) && (cand != acc);

  always_comb begin
    legal = 1'b1;
    dec   = 2'd0;
    case (cand)
      6'b110011: dec = 2'd0;
      6'b101011: dec = 2'd1;
      6'b011110: dec = 2'd2;
      6'b011101: dec = 2'd3;
      default:   legal = 1'b0;
    endcase
  end

  assign succ      = phase + 2'd1;
  assign dwell_inc = (dwell == 8'hFF) ? dwell : dwell + 8'd1;
  assign min_cur   = phase[0] ? Y_MIN : G_MIN;
  assign max_cur   = phase[0] ? Y_MAX : G_MAX;

  // The phase entered on lock is partial, so leaving it skips the minimum check
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    dwell_n   = dwell;
    cycles_n  = cycles;
    partial_n = partial;
    set_pat   = 1'b0;
    set_ord   = 1'b0;
    set_time  = 1'b0;
    if (accept) begin
      dwell_n = '0;
      if (state == UNLOCKED) begin
        if (legal) begin
          phase_n   = dec;
          state_n   = TRACK;
          partial_n = 1'b1;
        end else begin
          set_pat = 1'b1;
        end
      end else if (!legal) begin
        set_pat = 1'b1;
        state_n = UNLOCKED;
      end else if (dec == succ) begin
        if (!partial && dwell < min_cur) set_time = 1'b1;
        phase_n   = dec;
        partial_n = 1'b0;
        if (phase == 2'd3) cycles_n = cycles + 16'd1;
      end else begin
        set_ord   = 1'b1;
        phase_n   = dec;
        partial_n = 1'b0;
      end
    end else if (tick && state == TRACK) begin
      dwell_n = dwell_inc;
      if (dwell_inc > max_cur) set_time = 1'b1;
    end
  end

  assign ep_n = (err_pattern & ~clr_err) | set_pat;
  assign eo_n = (err_order   & ~clr_err) | set_ord;
  assign et_n = (err_time    & ~clr_err) | set_time;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UNLOCKED;
      phase       <= '0;
      locked      <= 1'b0;
      dwell       <= '0;
      cycles      <= '0;
      partial     <= 1'b0;
      err_pattern <= 1'b0;
      err_order   <= 1'b0;
      err_time    <= 1'b0;
      err_any     <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      locked      <= (state_n == TRACK);
      dwell       <= dwell_n;
      cycles      <= cycles_n;
      partial     <= partial_n;
      err_pattern <= ep_n;
      err_order   <= eo_n;
      err_time    <= et_n;
      err_any     <= ep_n | eo_n | et_n;
    end
  end
endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: the driver queues hand-computed expected
// snapshots; a negedge monitor pops and compares them against the outputs.
module tb_traffic_monitor;
  logic        clk = 1'b0;
  logic        rst, tick, clr_err;
  logic [5:0]  lamps;
  logic [1:0]  phase;
  logic        locked;
  logic [7:0]  dwell;
  logic [15:0] cycles;
  logic        err_pattern, err_order, err_time, err_any;

  localparam logic [5:0] S1 = 6'b110011;
  localparam logic [5:0] S2 = 6'b101011;
  localparam logic [5:0] S3 = 6'b011110;
  localparam logic [5:0] S4 = 6'b011101;
  localparam logic [5:0] BOTH_RED = 6'b011011;

  traffic_monitor dut (
    .clk(clk), .rst(rst), .tick(tick), .lamps(lamps), .clr_err(clr_err),
    .phase(phase), .locked(locked), .dwell(dwell), .cycles(cycles),
    .err_pattern(err_pattern), .err_order(err_order), .err_time(err_time),
    .err_any(err_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          cyc;
    logic        chk_phase;
    logic [1:0]  phase;
    logic        locked;
    logic [7:0]  dwell;
    logic [15:0] cycles;
    logic [3:0]  errs;   // {pattern, order, time, any}
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // expected state, maintained by hand in the stimulus
  logic [1:0]  e_phase;
  logic        e_pchk;
  logic        e_locked;
  logic [7:0]  e_dwell;
  logic [15:0] e_cycles;
  logic        e_ep, e_eo, e_et;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [3:0] act_errs;
      e = q.pop_front();
      act_errs = {err_pattern, err_order, err_time, err_any};
      checks++;
      if ((e.chk_phase && phase !== e.phase) || locked !== e.locked ||
          dwell !== e.dwell || cycles !== e.cycles || act_errs !== e.errs) begin
        errors++;
        $display("FAIL %s: got phase=%0d locked=%0b dwell=%0d cycles=%0d errs=%b, want phase=%0d%s locked=%0b dwell=%0d cycles=%0d errs=%b",
                 e.name, phase, locked, dwell, cycles, act_errs, e.phase,
                 e.chk_phase ? "" : "(any)", e.locked, e.dwell, e.cycles, e.errs);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
    end
  endtask

  task automatic apply(input logic [5:0] p);
    lamps = p;
    step(7);
  endtask

  task automatic chk(input string name);
    exp_t e;
    e.name      = name;
    e.cyc       = cyc;
    e.chk_phase = e_pchk;
    e.phase     = e_phase;
    e.locked    = e_locked;
    e.dwell     = e_dwell;
    e.cycles    = e_cycles;
    e.errs      = {e_ep, e_eo, e_et, e_ep | e_eo | e_et};
    q.push_back(e);
  endtask

  task automatic exp_reset();
    e_phase = 2'd0; e_pchk = 1'b1; e_locked = 1'b0; e_dwell = 8'd0;
    e_cycles = 16'd0; e_ep = 1'b0; e_eo = 1'b0; e_et = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; clr_err = 1'b0; lamps = 6'b111111;
    exp_reset();
    step(3);
    chk("reset");
    rst = 1'b0;

    // lock latency: outputs change on edge 6 after the new pattern is first sampled
    lamps = S1;
    step(6);
    chk("pre_lock_edge5");
    step(1);
    e_locked = 1'b1;
    chk("lock_edge6");
    step(13);
    chk("lock_hold");

    // three legal cycles 11/4/11/4
    for (int c = 1; c <= 3; c++) begin
      do_tick(11); e_dwell = 8'd11; chk("s1_dwell");
      apply(S2); e_phase = 2'd1; e_dwell = 8'd0; chk("to_s2");
      do_tick(4);
      apply(S3); e_phase = 2'd2; chk("to_s3");
      do_tick(11);
      apply(S4); e_phase = 2'd3; chk("to_s4");
      do_tick(4);
      apply(S1); e_phase = 2'd0; e_cycles = 16'(c); chk("to_s1_cycle");
    end

    // green overstay: 12 is allowed, 13 violates
    do_tick(12); e_dwell = 8'd12; chk("green_12_ok");
    do_tick(1);  e_dwell = 8'd13; e_et = 1'b1; chk("green_13_err");
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    e_et = 1'b0; chk("clr_no_tick");

    // out-of-order phase, then illegal pattern
    apply(S3); e_phase = 2'd2; e_dwell = 8'd0; e_eo = 1'b1; chk("order_err");
    apply(BOTH_RED); e_locked = 1'b0; e_ep = 1'b1; e_pchk = 1'b0; chk("pattern_err");
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    e_ep = 1'b0; e_eo = 1'b0; chk("clr_all");

    // relock, glitch in S2, then accept coinciding with a tick at yellow minimum
    apply(S1); e_locked = 1'b1; e_pchk = 1'b1; e_phase = 2'd0; chk("relock_s1");
    do_tick(10);
    apply(S2); e_phase = 2'd1; chk("relock_s2");
    do_tick(1);
    lamps = S3; step(2); lamps = S2; step(8);
    e_dwell = 8'd1; chk("glitch_ignored");
    do_tick(2);
    lamps = S3; step(6);
    tick = 1'b1; step(1); tick = 1'b0;
    e_phase = 2'd2; e_dwell = 8'd0; chk("accept_wins_tick");

    // pending err_time, then clr_err colliding with a fresh yellow overstay
    do_tick(13); e_dwell = 8'd13; e_et = 1'b1; chk("s3_overstay");
    apply(S4); e_phase = 2'd3; e_dwell = 8'd0; chk("s3_to_s4");
    do_tick(4);
    apply(S1); e_phase = 2'd0; e_cycles = 16'd4; chk("cycle4");
    do_tick(10);
    apply(S2); e_phase = 2'd1; chk("s2_again");
    do_tick(5); e_dwell = 8'd5; chk("yel_5_ok");
    clr_err = 1'b1; tick = 1'b1; step(1); clr_err = 1'b0; tick = 1'b0;
    e_dwell = 8'd6; chk("set_beats_clr");
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    e_et = 1'b0; chk("clr_after");
    apply(S3); e_phase = 2'd2; e_dwell = 8'd0; chk("s2_to_s3");
    do_tick(2);

    // reset mid-S3
    rst = 1'b1; step(1);
    exp_reset(); chk("rst_mid");
    rst = 1'b0;
    step(6); chk("no_track_before_accept");
    step(1); e_locked = 1'b1; e_phase = 2'd2; chk("relock_after_rst");

    // leaving the partial first phase skips the minimum; the next one does not
    apply(S4); e_phase = 2'd3; chk("partial_no_min");
    apply(S1); e_phase = 2'd0; e_cycles = 16'd1; e_et = 1'b1; chk("yel_min_err");

    step(3);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
